sync_ram_scan: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request port, registered one-cycle read latency, and an optional built-in scan engine that reads every location in address order. It is the next-generation storage block for the lab memory subsystem: it supersedes the fixed 8x4 combinational ROM with a clocked, writable, width/depth-configurable array. The scan engine replaces the manual address sweep the bench used to drive.

---
 rtl/sync_ram_scan.sv | 161 ++++++++++++++++
 tb/tb_sync_ram_scan.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_ram_scan.sv
// sync_ram_scan
//   Single-port synchronous RAM with a valid/ready request port and a
//   registered, one-cycle read path. An optional scan engine reads every
//   implemented word in address order through the same response port.
//
//   Optional feature macro: SCAN_EN
//     defined   -> scan engine and IDLE/SCAN/DONE FSM compiled in
//     undefined -> scan_start ignored, scan_busy = scan_done = 0,
//                  req_ready = 1 permanently
//
// Parameters
//   DATA_W  word width
//   ADDR_W  address width
//   DEPTH   implemented words, 1 <= DEPTH <= 2**ADDR_W
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (accepted when both high)
//   req_we                1 = write, 0 = read
//   req_addr, req_wdata   request address / write data
//   rsp_valid             one-cycle pulse per read (host or scan)
//   rsp_data, rsp_addr    read data and the address that produced it
//   scan_start            pulse, starts a full-array scan (IDLE only)
//   scan_busy             scan in progress (SCAN or DONE)
//   scan_done             one-cycle pulse with the final scan response

module sync_ram_scan #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_done
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    // Storage is deliberately not reset: contents survive rst_n.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic              scan_issue;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_in_range;
    logic              rd_in_range;

`ifdef SCAN_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (scan_start) state_nxt = SCAN;
            SCAN:    if (scan_addr == LAST_ADDR) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state. The last scan read is issued in the
    // final SCAN cycle, so its response lands in DONE alongside scan_done.
    always_comb begin
        req_ready  = 1'b0;
        scan_busy  = 1'b0;
        scan_done  = 1'b0;
        scan_issue = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            SCAN: begin
                scan_busy  = 1'b1;
                scan_issue = 1'b1;
            end
            DONE: begin
                scan_busy = 1'b1;
                scan_done = 1'b1;
            end
            default: req_ready = 1'b1;
        endcase
    end

    // Scan address: cleared on start, saturates at DEPTH-1 so it never
    // points past the implemented array (covers DEPTH == 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_addr <= '0;
        end else if (state == IDLE && scan_start) begin
            scan_addr <= '0;
        end else if (state == SCAN && scan_addr != LAST_ADDR) begin
            scan_addr <= scan_addr + ADDR_W'(1);
        end
    end
`else
    logic unused_scan_start;

    assign unused_scan_start = scan_start;
    assign req_ready         = 1'b1;
    assign scan_busy         = 1'b0;
    assign scan_done         = 1'b0;
    assign scan_issue        = 1'b0;
    assign scan_addr         = '0;
`endif

    // Host and scan reads never coincide: host requests are only taken
    // in IDLE, scan reads only issue in SCAN.
    assign accept      = req_valid && req_ready && rst_n;
    assign wr_en       = accept && req_we;
    assign rd_en       = (accept && !req_we) || scan_issue;
    assign rd_addr     = scan_issue ? scan_addr : req_addr;
    assign wr_in_range = {1'b0, req_addr} < DEPTH_C;
    assign rd_in_range = {1'b0, rd_addr}  < DEPTH_C;

    // Out-of-range writes are accepted and dropped.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) mem[req_addr] <= req_wdata;
    end

    // Registered response; out-of-range reads return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
        end else begin
            rsp_valid <= rd_en;
            if (rd_en) begin
                rsp_addr <= rd_addr;
                rsp_data <= rd_in_range ? mem[rd_addr] : '0;
            end
        end
    end

endmodule

// File: tb/tb_sync_ram_scan.sv
// Directed, table-driven bench for sync_ram_scan (8-deep and 6-deep builds).
module tb_sync_ram_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_valid, req_we, scan_start;
    logic [2:0] req_addr;
    logic [3:0] req_wdata;
    logic       req_ready, rsp_valid, scan_busy, scan_done;
    logic [3:0] rsp_data;
    logic [2:0] rsp_addr;

    // DEPTH=6 instance, host port only
    logic       r6_valid, r6_we, r6_scan;
    logic [2:0] r6_addr;
    logic [3:0] r6_wdata;
    logic       r6_ready, r6_rvalid, r6_busy, r6_done;
    logic [3:0] r6_rdata;
    logic [2:0] r6_raddr;

    sync_ram_scan #(.DATA_W(4), .ADDR_W(3), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done)
    );

    sync_ram_scan #(.DATA_W(4), .ADDR_W(3), .DEPTH(6)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r6_valid), .req_ready(r6_ready), .req_we(r6_we),
        .req_addr(r6_addr), .req_wdata(r6_wdata),
        .rsp_valid(r6_rvalid), .rsp_data(r6_rdata), .rsp_addr(r6_raddr),
        .scan_start(r6_scan), .scan_busy(r6_busy), .scan_done(r6_done)
    );

    typedef struct {
        logic       we;
        logic [2:0] addr;
        logic [3:0] wdata;
        logic       ev;
        logic [3:0] ed;
        logic [2:0] ea;
    } vec_t;

    vec_t vt[18];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        chk({tag, " valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " data"},  32'(rsp_data),  32'd0);
        chk({tag, " addr"},  32'(rsp_addr),  32'd0);
        chk({tag, " busy"},  32'(scan_busy), 32'd0);
        chk({tag, " done"},  32'(scan_done), 32'd0);
    endtask

    function automatic logic [3:0] pat(input int i);
        return 4'(i) ^ 4'hA;
    endfunction

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        scan_start = 1'b0;
        r6_valid = 1'b0; r6_we = 1'b0; r6_addr = '0; r6_wdata = '0; r6_scan = 1'b0;

        // Pattern load, back-to-back readback, write-then-read
        for (int i = 0; i < 8; i++) begin
            vt[i].we = 1'b1; vt[i].addr = 3'(i); vt[i].wdata = pat(i);
            vt[i].ev = 1'b0; vt[i].ed = '0;      vt[i].ea = '0;
            vt[8+i].we = 1'b0; vt[8+i].addr = 3'(i); vt[8+i].wdata = '0;
            vt[8+i].ev = 1'b1; vt[8+i].ed = pat(i);  vt[8+i].ea = 3'(i);
        end
        vt[16].we = 1'b1; vt[16].addr = 3'd5; vt[16].wdata = 4'h3;
        vt[16].ev = 1'b0; vt[16].ed = '0;     vt[16].ea = '0;
        vt[17].we = 1'b0; vt[17].addr = 3'd5; vt[17].wdata = '0;
        vt[17].ev = 1'b1; vt[17].ed = 4'h3;   vt[17].ea = 3'd5;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            req_valid = 1'b1; req_we = vt[i].we; req_addr = vt[i].addr; req_wdata = vt[i].wdata;
            @(posedge clk); #1;
            chk($sformatf("vec%0d valid", i), 32'(rsp_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'd1);
            if (vt[i].ev) begin
                chk($sformatf("vec%0d data", i), 32'(rsp_data), 32'(vt[i].ed));
                chk($sformatf("vec%0d addr", i), 32'(rsp_addr), 32'(vt[i].ea));
            end
        end
        req_valid = 1'b0;
        // Restore pattern at addr 5 for the scan checks
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = pat(5);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // DEPTH=6: out-of-range write dropped, read returns 0
        r6_valid = 1'b1; r6_we = 1'b1; r6_addr = 3'd5; r6_wdata = 4'h6;
        @(posedge clk); #1;
        r6_addr = 3'd7; r6_wdata = 4'hF;
        @(posedge clk); #1;
        r6_we = 1'b0; r6_addr = 3'd7;
        @(posedge clk); #1;
        chk("d6 rd7 valid", 32'(r6_rvalid), 32'd1);
        chk("d6 rd7 data",  32'(r6_rdata),  32'd0);
        chk("d6 rd7 addr",  32'(r6_raddr),  32'd7);
        r6_addr = 3'd5;
        @(posedge clk); #1;
        chk("d6 rd5 data",  32'(r6_rdata),  32'd6);
        chk("d6 rd5 addr",  32'(r6_raddr),  32'd5);
        r6_valid = 1'b0;
        @(posedge clk); #1;
        chk("d6 idle valid", 32'(r6_rvalid), 32'd0);

        // scan_start together with a host read of addr 2
        scan_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
        @(posedge clk); #1;
        scan_start = 1'b0; req_valid = 1'b0;
        chk("s+1 valid", 32'(rsp_valid), 32'd1);
        chk("s+1 data",  32'(rsp_data),  32'(pat(2)));
        chk("s+1 addr",  32'(rsp_addr),  32'd2);
`ifdef SCAN_EN
        chk("s+1 busy",  32'(scan_busy), 32'd1);
        chk("s+1 ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                // Second start and a write while scanning: both ignored
                scan_start = 1'b1;
                req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd0; req_wdata = 4'h0;
            end else begin
                scan_start = 1'b0; req_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk($sformatf("scan%0d valid", k), 32'(rsp_valid), 32'd1);
            chk($sformatf("scan%0d addr", k),  32'(rsp_addr),  32'(k));
            chk($sformatf("scan%0d data", k),  32'(rsp_data),  32'(pat(k)));
            chk($sformatf("scan%0d done", k),  32'(scan_done), 32'(k == 7));
            chk($sformatf("scan%0d busy", k),  32'(scan_busy), 32'd1);
            chk($sformatf("scan%0d ready", k), 32'(req_ready), 32'd0);
        end
        scan_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        @(posedge clk); #1;
        chk("s+10 ready", 32'(req_ready), 32'd1);
        chk("s+10 busy",  32'(scan_busy), 32'd0);
        chk("s+10 done",  32'(scan_done), 32'd0);
        chk("s+10 valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("post-scan rd0", 32'(rsp_data), 32'(pat(0)));
`else
        chk("noscan busy",  32'(scan_busy), 32'd0);
        chk("noscan ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("noscan done",  32'(scan_done), 32'd0);
        chk("noscan valid", 32'(rsp_valid), 32'd0);
`endif

        // Reset in the middle of a scan (cycle S+4)
        scan_start = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifdef SCAN_EN
        chk("s+4 busy",  32'(scan_busy), 32'd1);
        chk("s+4 addr",  32'(rsp_addr),  32'd2);
`else
        chk("s+4 busy",  32'(scan_busy), 32'd0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("async rst");
        // Host write attempted during reset must be ignored
        req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd3; req_wdata = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst done",  32'(scan_done), 32'd0);
        chk("rst valid", 32'(rsp_valid), 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("post-rst valid", 32'(rsp_valid), 32'd1);
        chk("post-rst data",  32'(rsp_data),  32'(pat(3)));
        chk("post-rst addr",  32'(rsp_addr),  32'd3);
        @(posedge clk); #1;
        chk("post-rst pulse", 32'(rsp_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
